// File: rtl/tensor_core_pkg.sv
// Shared constants and types for the tensor-core operand loader.
// Tile geometry and beat counts are fixed by the 4x4 MMA array.
package tensor_core_pkg;

    localparam int TILE_DIM    = 4;
    localparam int BEATS_FULL  = 12;
    localparam int BEATS_CZERO = 8;

    typedef enum logic {
        LOAD  = 1'b0,
        ISSUE = 1'b1
    } load_state_t;

    // Index of the last beat of a tile, given whether C beats are skipped.
    function automatic logic [3:0] final_beat(input logic c_zero);
        return c_zero ? 4'(BEATS_CZERO - 1) : 4'(BEATS_FULL - 1);
    endfunction

endpackage

// File: rtl/tile_row_bank.sv
// Four-row operand register bank: one row written per beat, whole bank
// cleared synchronously on request.
module tile_row_bank
    import tensor_core_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        clr,
    input  logic                                        wr_en,
    input  logic [1:0]                                  wr_row,
    input  logic [0:TILE_DIM-1][DWIDTH-1:0]             wr_data,
    output logic [0:TILE_DIM-1][0:TILE_DIM-1][DWIDTH-1:0] rows
);

    logic [0:TILE_DIM-1][DWIDTH-1:0] row_reg [TILE_DIM];

    genvar gi;
    generate
        for (gi = 0; gi < TILE_DIM; gi++) begin : g_row
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    row_reg[gi] <= '0;
                end else if (clr) begin
                    row_reg[gi] <= '0;
                end else if (wr_en && (wr_row == 2'(gi))) begin
                    row_reg[gi] <= wr_data;
                end
            end

            assign rows[gi] = row_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/tensor_core_tile_loader.sv
// Assembles streamed operand rows into A/B/C tiles and hands each complete
// tile to the MMA array over a valid/ready handshake.
module tensor_core_tile_loader
    import tensor_core_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    input  logic [0:TILE_DIM-1][DWIDTH-1:0]             s_row,
    input  logic                                        s_c_zero,
    input  logic                                        s_last,
    output logic                                        mma_valid,
    input  logic                                        mma_ready,
    output logic [0:TILE_DIM-1][0:TILE_DIM-1][DWIDTH-1:0] A_out,
    output logic [0:TILE_DIM-1][0:TILE_DIM-1][DWIDTH-1:0] B_out,
    output logic [0:TILE_DIM-1][0:TILE_DIM-1][DWIDTH-1:0] C_out,
    output logic                                        protocol_err
);

    load_state_t state_reg;
    logic [3:0]  beat_reg;
    logic        c_zero_reg;
    logic        s_ready_reg;
    logic        mma_valid_reg;
    logic        protocol_err_reg;

    logic        accept;
    logic        c_zero_eff;
    logic        is_final;
    logic        beat_err;
    logic        tile_done;
    logic        clr_c;

    logic [0:TILE_DIM-1][0:TILE_DIM-1][DWIDTH-1:0] bank_rows [3];

    assign accept     = s_valid && s_ready_reg;
    // On beat 0 the flag is not yet latched, so use the live input.
    assign c_zero_eff = (beat_reg == 4'd0) ? s_c_zero : c_zero_reg;
    assign is_final   = (beat_reg == final_beat(c_zero_eff));
    assign beat_err   = accept && (s_last != is_final);
    assign tile_done  = accept && s_last && is_final;
    assign clr_c      = tile_done && c_zero_eff;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bank
            tile_row_bank #(
                .DWIDTH (DWIDTH)
            ) u_bank (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     ((gi == 2) ? clr_c : 1'b0),
                .wr_en   (accept && (beat_reg[3:2] == 2'(gi))),
                .wr_row  (beat_reg[1:0]),
                .wr_data (s_row),
                .rows    (bank_rows[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= LOAD;
            beat_reg         <= 4'd0;
            c_zero_reg       <= 1'b0;
            s_ready_reg      <= 1'b0;
            mma_valid_reg    <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    s_ready_reg <= 1'b1;
                    if (accept) begin
                        if (beat_reg == 4'd0) begin
                            c_zero_reg <= s_c_zero;
                        end
                        if (beat_err) begin
                            protocol_err_reg <= 1'b1;
                            beat_reg         <= 4'd0;
                        end else if (tile_done) begin
                            beat_reg      <= 4'd0;
                            state_reg     <= ISSUE;
                            s_ready_reg   <= 1'b0;
                            mma_valid_reg <= 1'b1;
                        end else begin
                            beat_reg <= beat_reg + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    if (mma_ready) begin
                        state_reg     <= LOAD;
                        mma_valid_reg <= 1'b0;
                        s_ready_reg   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign s_ready      = s_ready_reg;
    assign mma_valid    = mma_valid_reg;
    assign protocol_err = protocol_err_reg;
    assign A_out        = bank_rows[0];
    assign B_out        = bank_rows[1];
    assign C_out        = bank_rows[2];

endmodule

// File: tb/tb_tensor_core_tile_loader.sv
// Directed and randomized checks of the tile loader against a matrix-level
// reference: each tile is generated as whole matrices and compared on issue.
module tb_tensor_core_tile_loader;

    localparam int DW = 16;
    typedef logic [0:3][0:3][DW-1:0] mat_t;
    typedef logic [0:3][DW-1:0]      row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic s_valid = 1'b0;
    logic s_ready;
    row_t s_row = '0;
    logic s_c_zero = 1'b0;
    logic s_last = 1'b0;
    logic mma_valid;
    logic mma_ready = 1'b1;
    mat_t A_out, B_out, C_out;
    logic protocol_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tensor_core_tile_loader #(
        .DWIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_row        (s_row),
        .s_c_zero     (s_c_zero),
        .s_last       (s_last),
        .mma_valid    (mma_valid),
        .mma_ready    (mma_ready),
        .A_out        (A_out),
        .B_out        (B_out),
        .C_out        (C_out),
        .protocol_err (protocol_err)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                m[r][k] = DW'($urandom);
        return m;
    endfunction

    // Offers one beat (after optional random bubbles) and returns at the
    // falling edge following its acceptance.
    task automatic send_beat(input row_t row, input logic last, input logic cz, input int bub_pct);
        int guard = 0;
        while ($urandom_range(99) < bub_pct) begin
            s_valid = 1'b0;
            s_row   = row_t'({$urandom, $urandom});
            @(negedge clk);
        end
        s_valid  = 1'b1;
        s_row    = row;
        s_last   = last;
        s_c_zero = cz;
        while (!s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("beat_accept_timeout", 1'b0, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_tile(input mat_t a, input mat_t b, input mat_t c, input logic cz, input int bub_pct);
        int n = cz ? 8 : 12;
        for (int i = 0; i < n; i++) begin
            row_t r;
            if (i < 4)      r = a[i];
            else if (i < 8) r = b[i-4];
            else            r = c[i-8];
            send_beat(r, (i == n - 1), (i == 0) ? cz : 1'($urandom_range(1)), bub_pct);
        end
    endtask

    // Checks the cycle right after the final beat, then the handshake cycle.
    task automatic expect_issue(input string tag, input mat_t a, input mat_t b, input mat_t c, input logic cz);
        mat_t c_exp = cz ? '0 : c;
        check({tag, "_valid"}, mma_valid, 1'b1);
        check({tag, "_A"}, A_out, a);
        check({tag, "_B"}, B_out, b);
        check({tag, "_C"}, C_out, c_exp);
        @(negedge clk);
        check({tag, "_valid_drop"}, mma_valid, 1'b0);
        check({tag, "_ready_back"}, s_ready, 1'b1);
    endtask

    initial begin
        mat_t a, b, c, held_a;

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_mma_valid", mma_valid, 1'b0);
        check("rst_err", protocol_err, 1'b0);
        check("rst_A", A_out, '0);
        check("rst_B", B_out, '0);
        check("rst_C", C_out, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", s_ready, 1'b1);

        // Full tile: identity A, B = 1..16, C = 100..115
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
                a[r][k] = (r == k) ? DW'(1) : DW'(0);
                b[r][k] = DW'(r * 4 + k + 1);
                c[r][k] = DW'(100 + r * 4 + k);
            end
        send_tile(a, b, c, 1'b0, 0);
        check("full_B12", B_out[1][2], DW'(7));
        check("full_C33", C_out[3][3], DW'(115));
        expect_issue("full", a, b, c, 1'b0);

        // c_zero tile over stale nonzero C
        a = rand_mat();
        b = rand_mat();
        send_tile(a, b, rand_mat(), 1'b1, 0);
        expect_issue("czero", a, b, '0, 1'b1);

        // Backpressure: hold mma_ready low for 5 cycles while offering beats
        a = rand_mat();
        b = rand_mat();
        c = rand_mat();
        held_a = a;
        mma_ready = 1'b0;
        send_tile(a, b, c, 1'b0, 0);
        check("bp_valid", mma_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_row   = row_t'({$urandom, $urandom});
            s_last  = 1'b1;
            @(negedge clk);
            check("bp_hold_valid", mma_valid, 1'b1);
            check("bp_hold_ready", s_ready, 1'b0);
            check("bp_hold_A", A_out, held_a);
            check("bp_hold_C", C_out, c);
        end
        s_valid   = 1'b0;
        s_last    = 1'b0;
        mma_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", mma_valid, 1'b0);
        check("bp_release_ready", s_ready, 1'b1);
        a = rand_mat();
        b = rand_mat();
        c = rand_mat();
        send_tile(a, b, c, 1'b0, 0);
        expect_issue("bp_next", a, b, c, 1'b0);

        // Early s_last on beat 5
        check("pre_err", protocol_err, 1'b0);
        for (int i = 0; i < 6; i++) send_beat(row_t'({$urandom, $urandom}), (i == 5), 1'b0, 0);
        check("early_err", protocol_err, 1'b1);
        check("early_no_valid", mma_valid, 1'b0);
        @(negedge clk);
        check("early_no_valid2", mma_valid, 1'b0);
        a = rand_mat();
        b = rand_mat();
        c = rand_mat();
        send_tile(a, b, c, 1'b0, 0);
        expect_issue("after_err", a, b, c, 1'b0);
        check("err_sticky", protocol_err, 1'b1);

        // Reset mid-load after 6 beats
        for (int i = 0; i < 6; i++) send_beat(row_t'({$urandom | 1, $urandom}), 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_A", A_out, '0);
        check("midrst_B", B_out, '0);
        check("midrst_C", C_out, '0);
        check("midrst_ready", s_ready, 1'b0);
        check("midrst_err", protocol_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        a = rand_mat();
        b = rand_mat();
        c = rand_mat();
        send_tile(a, b, c, 1'b0, 0);
        expect_issue("after_rst", a, b, c, 1'b0);

        // Random tiles with ~50% input bubbles
        for (int t = 0; t < 6; t++) begin
            logic cz = 1'($urandom_range(1));
            a = rand_mat();
            b = rand_mat();
            c = rand_mat();
            send_tile(a, b, c, cz, 50);
            expect_issue($sformatf("rand%0d", t), a, b, c, cz);
        end
        check("final_err_clear", protocol_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
